// File: rtl/bit_switch_pkg.sv
// bit_switch_pkg: shared state encoding and requester ids for the bit-serial switch scheduler
package bit_switch_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
  localparam logic ID_R0 = 1'b0;
  localparam logic ID_R1 = 1'b1;
endpackage

// File: rtl/bit_switch_sched_rr_arb2.sv
// rr_arb2: two-way round-robin grant, favouring the requester that did not win last
// Ports: req0/req1 requests, last_grant previous winner, gnt_valid any request, gnt_id winner.
module rr_arb2
  import bit_switch_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);
  assign gnt_valid = req0 | req1;
  assign gnt_id    = (req0 & req1) ? ~last_grant : (req1 ? ID_R1 : ID_R0);
endmodule

// File: rtl/bit_switch_sched.sv
// bit_switch_sched: arbitrates two requesters onto a shared bit-serial XOR switch
// Ports: clk, rst (async, active-high); req0/req1, data0/data1, inv0/inv1 per requester;
// ack0/ack1 completion pulses; result/result_valid/result_id finished word; busy while not idle.
module bit_switch_sched
  import bit_switch_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             inv0,
  input  logic             inv1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             result_id,
  output logic             busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  state_t           state, next_state;
  logic [WIDTH-1:0] shreg, acc;
  logic [CW-1:0]    cnt;
  logic             inv_q, id_q, last_grant, gnt_valid, gnt_id, sbit;
  logic             rv_d, ack0_d, ack1_d;
  rr_arb2 u_arb (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  // DONE and the unused encoding both fall back to IDLE
  always_comb
    next_state = (state == ST_IDLE)  ? (gnt_valid ? ST_SHIFT : ST_IDLE) :
                 (state == ST_SHIFT) ? ((cnt == '0) ? ST_DONE : ST_SHIFT) : ST_IDLE;
  always_comb begin
    rv_d   = (state == ST_DONE);
    ack0_d = rv_d & (id_q == ID_R0);
    ack1_d = rv_d & (id_q == ID_R1);
    sbit   = shreg[0] ^ inv_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shreg        <= '0;
      acc          <= '0;
      cnt          <= '0;
      inv_q        <= 1'b0;
      id_q         <= ID_R0;
      last_grant   <= ID_R1;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      result_id    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      ack0         <= ack0_d;
      ack1         <= ack1_d;
      result_valid <= rv_d;
      busy         <= (next_state != ST_IDLE);
      if (state == ST_IDLE && gnt_valid) begin
        shreg <= gnt_id ? data1 : data0;
        inv_q <= gnt_id ? inv1 : inv0;
        id_q  <= gnt_id;
        cnt   <= CW'(WIDTH - 1);
        acc   <= '0;
      end
      // each processed bit enters at the MSB, so after WIDTH shifts the word is back in order
      if (state == ST_SHIFT) begin
        acc   <= (acc >> 1) | (WIDTH'(sbit) << (WIDTH - 1));
        shreg <= shreg >> 1;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
      if (rv_d) begin
        result     <= acc;
        result_id  <= id_q;
        last_grant <= id_q;
      end
    end
endmodule

// File: tb/tb_bit_switch_sched.sv
// tb_bit_switch_sched: directed scoreboard bench for bit_switch_sched (WIDTH=8 and WIDTH=1)
module tb_bit_switch_sched;
  typedef struct {
    logic       id;
    logic [7:0] res;
  } exp_t;
  logic       clk = 1'b0, rst = 1'b1;
  logic       req0 = 0, req1 = 0, inv0 = 0, inv1 = 0;
  logic [7:0] data0 = 0, data1 = 0;
  logic       ack0, ack1, result_valid, result_id, busy;
  logic [7:0] result;
  logic       w_req0 = 0, w_req1 = 0, w_inv0 = 0, w_inv1 = 0;
  logic [0:0] w_data0 = 0, w_data1 = 0;
  logic       w_ack0, w_ack1, w_rv, w_rid, w_busy;
  logic [0:0] w_result;
  exp_t       sb[$];
  int         n_chk = 0, n_fail = 0;
  int         cyc;
  always #5 clk = ~clk;
  bit_switch_sched #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .inv0(inv0), .inv1(inv1), .ack0(ack0), .ack1(ack1), .result(result),
    .result_valid(result_valid), .result_id(result_id), .busy(busy)
  );
  bit_switch_sched #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .req0(w_req0), .req1(w_req1), .data0(w_data0), .data1(w_data1),
    .inv0(w_inv0), .inv1(w_inv1), .ack0(w_ack0), .ack1(w_ack1), .result(w_result),
    .result_valid(w_rv), .result_id(w_rid), .busy(w_busy)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req_v);
    n_chk++;
    assert (obs === req_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req_v);
    end
  endtask
  task automatic wait_rv(input int start, output int c);
    c = start;
    do begin
      @(negedge clk);
      c++;
    end while (!result_valid && c < 40);
    if (!result_valid) check("timeout_rv", 32'd0, 32'd1);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (ack0 && ack1) check("ack_exclusive", 32'd1, 32'd0);
    if ((ack0 | ack1) !== result_valid) check("ack_vs_valid", {31'd0, ack0 | ack1}, {31'd0, result_valid});
    if (result_valid) begin
      if (sb.size() == 0) check("unexpected_result", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("result", {24'd0, result}, {24'd0, e.res});
        check("result_id", {31'd0, result_id}, {31'd0, e.id});
        check("ack0", {31'd0, ack0}, {31'd0, e.id == 1'b0});
        check("ack1", {31'd0, ack1}, {31'd0, e.id == 1'b1});
      end
    end
  end
  initial begin
    #1;
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_outs", {27'd0, ack0, ack1, result_valid, result_id, busy}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    // single request from requester 0, inverted
    data0 = 8'hA5; inv0 = 1; req0 = 1;
    sb.push_back('{1'b0, 8'h5A});
    wait_rv(0, cyc);
    check("lat_r0", cyc, 10);
    req0 = 0;
    // single request from requester 1, pass-through
    data1 = 8'h3C; inv1 = 0; req1 = 1;
    sb.push_back('{1'b1, 8'h3C});
    wait_rv(0, cyc);
    check("lat_r1", cyc, 10);
    req1 = 0;
    repeat (3) @(negedge clk);
    check("result_hold", {24'd0, result}, 32'h3C);
    check("idle_busy", {31'd0, busy}, 32'd0);
    // simultaneous requests right after reset: requester 0 wins the tie
    rst = 1; @(negedge clk); rst = 0;
    data0 = 8'hFF; inv0 = 1; data1 = 8'h0F; inv1 = 1; req0 = 1; req1 = 1;
    sb.push_back('{1'b0, 8'h00});
    sb.push_back('{1'b1, 8'hF0});
    wait_rv(0, cyc);
    check("lat_tie0", cyc, 10);
    req0 = 0;
    wait_rv(0, cyc);
    check("gap_tie1", cyc, 10);
    req1 = 0;
    @(negedge clk);
    // both held: strict alternation starting with requester 0
    data0 = 8'h11; inv0 = 0; data1 = 8'h22; inv1 = 1; req0 = 1; req1 = 1;
    for (int i = 0; i < 6; i++) sb.push_back('{i[0], i[0] ? 8'hDD : 8'h11});
    for (int i = 0; i < 6; i++) begin
      wait_rv(0, cyc);
      check("gap_alt", cyc, 10);
    end
    req0 = 0; req1 = 0;
    repeat (2) @(negedge clk);
    check("alt_drained", sb.size(), 0);
    // reset in the 4th shift cycle drops the transaction
    data0 = 8'h55; inv0 = 0; req0 = 1;
    repeat (4) @(negedge clk);
    check("busy_mid_shift", {31'd0, busy}, 32'd1);
    #1 rst = 1; req0 = 0;
    #1;
    check("rst_async_outs", {27'd0, ack0, ack1, result_valid, result_id, busy}, 32'd0);
    check("rst_async_result", {24'd0, result}, 32'd0);
    @(negedge clk); rst = 0;
    repeat (12) @(negedge clk);
    check("no_ack_after_rst", {31'd0, busy}, 32'd0);
    data0 = 8'h81; inv0 = 1; req0 = 1;
    sb.push_back('{1'b0, 8'h7E});
    wait_rv(0, cyc);
    check("lat_after_rst", cyc, 10);
    req0 = 0;
    // request dropped and data changed mid-transaction: captured word still completes
    data0 = 8'hC3; inv0 = 0; req0 = 1;
    sb.push_back('{1'b0, 8'hC3});
    repeat (2) @(negedge clk);
    req0 = 0; data0 = 8'h00; inv0 = 1;
    wait_rv(2, cyc);
    check("lat_dropped", cyc, 10);
    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    // single-bit build
    w_data0 = 1'b1; w_inv0 = 1; w_req0 = 1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!w_rv && cyc < 20);
    w_req0 = 0;
    check("w1_lat", cyc, 3);
    check("w1_result", {31'd0, w_result}, 32'd0);
    check("w1_ack", {30'd0, w_ack0, w_ack1}, 32'd2);
    check("w1_id", {31'd0, w_rid}, 32'd0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
